// File: rtl/micro_ucr_miner.sv
// Iterative micro-ucr-hash miner: searches an inclusive, wrapping nonce range
// for {payload, nonce} whose H0 and H1 both fall below the target.
module micro_ucr_miner #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        active,
    input  logic        start,
    input  logic        stop,
    input  logic [95:0] payload,
    input  logic [7:0]  target,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
    output logic        busy,
    output logic        terminado,
    output logic        agotado,
    output logic [31:0] nonceOut,
    output logic [23:0] hashOut,
    output logic [31:0] hashCount
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rounds
        $error("micro_ucr_miner: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    localparam logic [7:0] H0_INIT  = 8'h01;
    localparam logic [7:0] H1_INIT  = 8'h89;
    localparam logic [7:0] H2_INIT  = 8'hFE;
    localparam logic [4:0] STEP     = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_IDX = 5'(32 - ROUNDS_PER_CYCLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_CHECK,
        S_FOUND,
        S_DONE
    } state_t;

    function automatic logic [31:0][7:0] expand(input logic [127:0] blk);
        logic [31:0][7:0] w;
        for (int i = 0; i < 16; i++) w[i] = blk[127 - 8*i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        return w;
    endfunction

    function automatic logic [23:0] round_step(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [4:0] idx,
                                               input logic [7:0] wi);
        logic [7:0] q;
        logic [7:0] k;
        if (idx <= 5'd16) begin
            q = a ^ b;
            k = 8'h99;
        end else begin
            q = a | b;
            k = 8'hA1;
        end
        return {b ^ c, {c[3:0], 4'h0}, q + k + wi};
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [95:0]      r_payload;
    logic [7:0]       r_target;
    logic [31:0]      r_nonce;
    logic [31:0]      r_nonce_end;
    logic [31:0][7:0] r_w;
    logic [7:0]       r_a, r_b, r_c;
    logic [4:0]       r_idx;
    logic [7:0]       w_a_nxt, w_b_nxt, w_c_nxt;
    logic [7:0]       w_h0, w_h1, w_h2;
    logic             w_valid;
    logic             w_launch;
    logic             w_last_round;
    logic             w_at_end;
    logic             r_terminado, r_agotado;
    logic [31:0]      r_nonce_out;
    logic [23:0]      r_hash_out;
    logic [31:0]      r_hash_count;

    assign w_launch     = start && !stop &&
                          (r_state == S_IDLE || r_state == S_FOUND || r_state == S_DONE);
    assign w_last_round = (r_idx == LAST_IDX);
    assign w_at_end     = (r_nonce == r_nonce_end);

    assign w_h0    = H0_INIT + r_a;
    assign w_h1    = H1_INIT + r_b;
    assign w_h2    = H2_INIT + r_c;
    assign w_valid = (w_h0 < r_target) && (w_h1 < r_target);

    // NOTE: blocking assignments here chain R rounds combinationally within one clock.
    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        w_c_nxt = r_c;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            {w_a_nxt, w_b_nxt, w_c_nxt} = round_step(w_a_nxt, w_b_nxt, w_c_nxt,
                                                     r_idx + 5'(j), r_w[r_idx + 5'(j)]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FOUND, S_DONE: if (start) w_state_nxt = S_LOAD;
                S_LOAD:                  w_state_nxt = S_ROUND;
                S_ROUND:                 if (w_last_round) w_state_nxt = S_CHECK;
                S_CHECK: begin
                    if (w_valid)       w_state_nxt = S_FOUND;
                    else if (w_at_end) w_state_nxt = S_DONE;
                    else               w_state_nxt = S_LOAD;
                end
                default:                 w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge active) begin
        if (!active) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // NOTE: pure datapath (captured inputs, schedule, working vars) has no reset;
    // every field is written before the FSM ever reads it.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_payload   <= payload;
            r_target    <= target;
            r_nonce     <= nonce_start;
            r_nonce_end <= nonce_end;
        end else if (r_state == S_CHECK && w_state_nxt == S_LOAD) begin
            r_nonce <= r_nonce + 32'd1;
        end
        if (r_state == S_LOAD) begin
            r_w   <= expand({r_payload, r_nonce});
            r_a   <= H0_INIT;
            r_b   <= H1_INIT;
            r_c   <= H2_INIT;
            r_idx <= 5'd0;
        end else if (r_state == S_ROUND) begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_c   <= w_c_nxt;
            r_idx <= r_idx + STEP;
        end
    end

    always_ff @(posedge clk or negedge active) begin
        if (!active) begin
            r_terminado  <= 1'b0;
            r_agotado    <= 1'b0;
            r_nonce_out  <= 32'd0;
            r_hash_out   <= 24'hFFFFFF;
            r_hash_count <= 32'd0;
        end else if (w_launch) begin
            r_terminado  <= 1'b0;
            r_agotado    <= 1'b0;
            r_hash_count <= 32'd0;
        end else if (!stop && r_state == S_CHECK) begin
            if (r_hash_count != 32'hFFFF_FFFF) r_hash_count <= r_hash_count + 32'd1;
            if (w_valid) begin
                r_terminado <= 1'b1;
                r_nonce_out <= r_nonce;
                r_hash_out  <= {w_h0, w_h1, w_h2};
            end else if (w_at_end) begin
                r_agotado <= 1'b1;
            end
        end
    end

    assign busy      = (r_state == S_LOAD) || (r_state == S_ROUND) || (r_state == S_CHECK);
    assign terminado = r_terminado;
    assign agotado   = r_agotado;
    assign nonceOut  = r_nonce_out;
    assign hashOut   = r_hash_out;
    assign hashCount = r_hash_count;

endmodule

// File: tb/tb_micro_ucr_miner.sv
// Runs one miner per legal ROUNDS_PER_CYCLE on shared stimulus and scores
// every result and its latency against an in-bench golden model.
module tb_micro_ucr_miner;

    localparam int NDUT = 6;

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        logic [23:0] hash;
        logic [31:0] count;
        int          cycles;
    } exp_t;

    logic             clk = 1'b0;
    logic             active = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [95:0]      payload = '0;
    logic [7:0]       target = '0;
    logic [31:0]      nonce_start = '0;
    logic [31:0]      nonce_end = '0;
    logic [NDUT-1:0]  busy_v, term_v, ago_v;
    logic [31:0]      nonce_v [NDUT];
    logic [23:0]      hash_v  [NDUT];
    logic [31:0]      cnt_v   [NDUT];

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        micro_ucr_miner #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .active     (active),
            .start      (start),
            .stop       (stop),
            .payload    (payload),
            .target     (target),
            .nonce_start(nonce_start),
            .nonce_end  (nonce_end),
            .busy       (busy_v[g]),
            .terminado  (term_v[g]),
            .agotado    (ago_v[g]),
            .nonceOut   (nonce_v[g]),
            .hashOut    (hash_v[g]),
            .hashCount  (cnt_v[g])
        );
    end

    function automatic int cyc_per_nonce(int g);
        return 32 / (1 << g) + 2;
    endfunction

    function automatic logic [23:0] model_hash(input logic [95:0] pl, input logic [31:0] n);
        logic [127:0] blk;
        logic [7:0]   w [32];
        logic [7:0]   a, b, c, q, k, t;
        blk = {pl, n};
        for (int i = 0; i < 16; i++) w[i] = blk[127 - 8*i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01;
        b = 8'h89;
        c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            if (i <= 16) begin k = 8'h99; q = a ^ b; end
            else         begin k = 8'hA1; q = a | b; end
            t = q + k + w[i];
            a = b ^ c;
            b = c << 4;
            c = t;
        end
        return {8'h01 + a, 8'h89 + b, 8'hFE + c};
    endfunction

    task automatic model_search(input logic [95:0] pl, input logic [7:0] tg,
                                input logic [31:0] ns, input logic [31:0] ne,
                                output logic found, output logic [31:0] nonce,
                                output logic [23:0] hash, output logic [31:0] count);
        logic [31:0] n;
        logic [23:0] h;
        n = ns;
        count = 0;
        found = 1'b0;
        nonce = 0;
        hash = 0;
        for (int guard = 0; guard < 100000; guard++) begin
            h = model_hash(pl, n);
            count++;
            if (h[23:16] < tg && h[15:8] < tg) begin
                found = 1'b1;
                nonce = n;
                hash = h;
                break;
            end
            if (n == ne) break;
            n = n + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input string name, input logic [95:0] pl, input logic [7:0] tg,
                       input logic [31:0] ns, input logic [31:0] ne);
        exp_t e;
        int   done_cyc [NDUT];
        int   c;
        logic all_done;
        payload = pl;
        target = tg;
        nonce_start = ns;
        nonce_end = ne;
        model_search(pl, tg, ns, ne, e.found, e.nonce, e.hash, e.count);
        for (int g = 0; g < NDUT; g++) begin
            e.cycles = int'(e.count) * cyc_per_nonce(g);
            sb.push_back(e);
            done_cyc[g] = -1;
        end
        pulse_start();
        check({name, " busy_rise"}, 32'(busy_v), 32'h3F);
        c = 0;
        all_done = 1'b0;
        while (!all_done && c < 3000) begin
            tick();
            c++;
            all_done = 1'b1;
            for (int g = 0; g < NDUT; g++) begin
                if (done_cyc[g] < 0 && !busy_v[g]) done_cyc[g] = c;
                if (done_cyc[g] < 0) all_done = 1'b0;
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            string r;
            r = $sformatf("%s R%0d", name, 1 << g);
            e = sb.pop_front();
            check({r, " cycles"}, 32'(done_cyc[g]), 32'(e.cycles));
            check({r, " terminado"}, 32'(term_v[g]), 32'(e.found));
            check({r, " agotado"}, 32'(ago_v[g]), 32'(!e.found));
            check({r, " hashCount"}, cnt_v[g], e.count);
            if (e.found) begin
                check({r, " nonceOut"}, nonce_v[g], e.nonce);
                check({r, " hashOut"}, 32'(hash_v[g]), 32'(e.hash));
            end
        end
    endtask

    initial begin
        logic [95:0] pl;
        logic [31:0] n;
        logic [23:0] h;
        logic [31:0] ns;

        repeat (3) tick();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset nonceOut R%0d", 1 << g), nonce_v[g], 32'd0);
            check($sformatf("reset hashOut R%0d", 1 << g), 32'(hash_v[g]), 32'h00FF_FFFF);
            check($sformatf("reset hashCount R%0d", 1 << g), cnt_v[g], 32'd0);
        end
        check("reset busy", 32'(busy_v), 32'd0);
        check("reset flags", 32'({term_v, ago_v}), 32'd0);
        active = 1'b1;
        tick();

        // Exhausted range: target 0 can never be met.
        run("exhaust", {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF}, 8'h00, 32'd5, 32'd7);

        // Single-nonce range chosen so that target 0xFF is met.
        pl = {32'hCAFEF00D, 32'h5A5A5A5A, 32'h0F1E2D3C};
        n = 32'h1234_5678;
        for (int i = 0; i < 100; i++) begin
            h = model_hash(pl, n);
            if (h[23:16] < 8'hFF && h[15:8] < 8'hFF) break;
            n = n + 1;
        end
        run("found1", pl, 8'hFF, n, n);

        run("wrap", {32'h11111111, 32'h22222222, 32'h33333333}, 8'h00, 32'hFFFF_FFFE, 32'h0000_0001);

        // Abort: a start while busy is ignored, stop wins over a coincident start.
        payload = {32'hA5A5A5A5, 32'h3C3C3C3C, 32'h77777777};
        target = 8'h00;
        nonce_start = 32'd100;
        nonce_end = 32'd100000;
        pulse_start();
        for (int c = 1; c < 20; c++) tick();
        payload = '1;
        target = 8'hFF;
        nonce_start = 32'd5;
        nonce_end = 32'd5;
        pulse_start();
        check("abort busy_at_20", 32'(busy_v), 32'h3F);
        for (int c = 21; c < 40; c++) tick();
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check("abort busy", 32'(busy_v), 32'd0);
        check("abort terminado", 32'(term_v), 32'd0);
        check("abort agotado", 32'(ago_v), 32'd0);
        check("abort hashCount R1", cnt_v[0], 32'd1);
        check("abort hashCount R2", cnt_v[1], 32'd2);
        tick();
        check("abort stays idle", 32'(busy_v), 32'd0);

        // Equivalence against the model with random payload, target and range.
        for (int t = 0; t < 4; t++) begin
            ns = $urandom;
            run($sformatf("rand%0d", t), {$urandom, $urandom, $urandom},
                8'($urandom_range(16, 64)), ns, ns + 32'($urandom_range(0, 20)));
        end

        // Async reset in the middle of a search, between clock edges.
        payload = {32'h0BADC0DE, 32'h10203040, 32'h50607080};
        target = 8'h00;
        nonce_start = 32'd0;
        nonce_end = 32'd1000;
        pulse_start();
        for (int c = 1; c <= 40; c++) tick();
        check("pre_reset hashCount R1", cnt_v[0], 32'd1);
        check("pre_reset busy", 32'(busy_v), 32'h3F);
        #3;
        active = 1'b0;
        #1;
        check("async busy", 32'(busy_v), 32'd0);
        check("async flags", 32'({term_v, ago_v}), 32'd0);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("async nonceOut R%0d", 1 << g), nonce_v[g], 32'd0);
            check($sformatf("async hashOut R%0d", 1 << g), 32'(hash_v[g]), 32'h00FF_FFFF);
            check($sformatf("async hashCount R%0d", 1 << g), cnt_v[g], 32'd0);
        end
        tick();
        active = 1'b1;
        tick();
        check("post_reset idle", 32'(busy_v), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
